// File: rtl/pwm_pkg.sv
// Shared definitions for the servo PWM generator and its analyzer bench.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package pwm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } pwm_state_e;

    // Default servo timing with a 1 us clock: 20 ms frame, 1.0-2.0 ms pulse.
    localparam int unsigned PWM_PERIOD_DEFAULT = 20000;
    localparam int unsigned PWM_MIN_DEFAULT    = 1000;
    localparam int unsigned PWM_MAX_DEFAULT    = 2000;
    localparam int unsigned PWM_RESET_DEFAULT  = 1500;

    function automatic logic [31:0] pwm_clamp(input logic [31:0] value,
                                              input logic [31:0] lo,
                                              input logic [31:0] hi);
        if (value < lo) begin
            return lo;
        end else if (value > hi) begin
            return hi;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/pwm_frame_counter.sv
// Modulo-PERIOD_COUNT frame counter with synchronous clear and count enable.
// Latency: next_cnt/wrap are combinational from the current count; count updates each enabled edge.
// Backpressure: none; the counter free-runs while enabled.
module pwm_frame_counter #(
    parameter int unsigned PERIOD_COUNT = 20000,
    parameter int unsigned CW           = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] next_cnt,
    output logic          wrap
);

    localparam logic [CW-1:0] LAST = CW'(PERIOD_COUNT - 1);

    logic [CW-1:0] cnt;

    assign wrap = en && !clr && (cnt == LAST);

    always_comb begin
        next_cnt = cnt;
        if (clr) begin
            next_cnt = '0;
        end else if (en) begin
            next_cnt = wrap ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= next_cnt;
        end
    end

endmodule

// File: rtl/pwm_servo_generator.sv
// Servo-style PWM frame generator with a double-buffered, clamped pulse width.
// Latency: pwm_out rises one cycle after en is sampled high; new widths apply at the next frame wrap.
// Backpressure: duty_ready is low while a loaded width is waiting for the next frame boundary.
module pwm_servo_generator
    import pwm_pkg::*;
#(
    parameter int unsigned PERIOD_COUNT = PWM_PERIOD_DEFAULT,
    parameter int unsigned MIN_PULSE    = PWM_MIN_DEFAULT,
    parameter int unsigned MAX_PULSE    = PWM_MAX_DEFAULT,
    parameter int unsigned DUTY_RESET   = PWM_RESET_DEFAULT,
    parameter int unsigned CW           = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [CW-1:0] duty_in,
    input  logic          duty_valid,
    output logic          duty_ready,
    output logic          pwm_out,
    output logic          frame_start,
    output logic          busy,
    output logic          clamped
);

    localparam logic [CW-1:0] DUTY_INIT = CW'(DUTY_RESET);

    pwm_state_e    state_q;
    pwm_state_e    state_d;
    logic [CW-1:0] active_q;
    logic [CW-1:0] active_d;
    logic [CW-1:0] shadow_q;
    logic          pending_q;

    logic          cnt_clr;
    logic          cnt_en;
    logic [CW-1:0] next_cnt;
    logic          wrap;

    logic          accept;
    logic          load_active;
    logic          saturated;
    logic [CW-1:0] duty_sat;
    logic          pwm_d;
    logic          frame_start_d;

    // Counter control depends only on the state register, keeping the compare path acyclic.
    assign cnt_clr = (state_q == ST_IDLE);
    assign cnt_en  = (state_q != ST_IDLE);

    pwm_frame_counter #(
        .PERIOD_COUNT(PERIOD_COUNT),
        .CW          (CW)
    ) u_frame_counter (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .next_cnt(next_cnt),
        .wrap    (wrap)
    );

    assign duty_ready = !pending_q;
    assign busy       = (state_q != ST_IDLE);
    assign accept     = duty_valid && duty_ready;

    assign saturated = (32'(duty_in) < MIN_PULSE) || (32'(duty_in) > MAX_PULSE);
    assign duty_sat  = CW'(pwm_clamp(32'(duty_in), MIN_PULSE, MAX_PULSE));

    // Idle transfers straight away; a running frame only ever swaps width at its wrap.
    assign load_active = pending_q && ((state_q == ST_IDLE) || wrap);
    assign active_d    = load_active ? shadow_q : active_q;

    always_comb begin
        state_d       = state_q;
        pwm_d         = 1'b0;
        frame_start_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d       = ST_RUN;
                    pwm_d         = 1'b1;
                    frame_start_d = 1'b1;
                end
            end
            ST_RUN, ST_STOP: begin
                pwm_d         = (next_cnt < active_d);
                frame_start_d = wrap;
                if (en) begin
                    state_d = ST_RUN;
                end else if ((state_q == ST_STOP) && wrap) begin
                    state_d       = ST_IDLE;
                    pwm_d         = 1'b0;
                    frame_start_d = 1'b0;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            active_q    <= DUTY_INIT;
            shadow_q    <= DUTY_INIT;
            pending_q   <= 1'b0;
            pwm_out     <= 1'b0;
            frame_start <= 1'b0;
            clamped     <= 1'b0;
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            pwm_out     <= pwm_d;
            frame_start <= frame_start_d;
            clamped     <= accept && saturated;
            if (accept) begin
                shadow_q  <= duty_sat;
                pending_q <= 1'b1;
            end else if (load_active) begin
                pending_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_servo_generator.sv
// Directed and randomized checks of pwm_servo_generator against a frame-level model.
module tb_pwm_servo_generator;

    localparam int P    = 20;
    localparam int MINP = 4;
    localparam int MAXP = 16;
    localparam int RSTW = 10;
    localparam int CW   = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [CW-1:0] duty_in = '0;
    logic          duty_valid = 1'b0;
    logic          duty_ready;
    logic          pwm_out;
    logic          frame_start;
    logic          busy;
    logic          clamped;

    int n_assert = 0;
    int n_fail   = 0;

    // Frame-level reference: position inside frame, width in force, queued width (-1 = none).
    bit m_on;
    bit m_stopping;
    int m_pos;
    int m_width;
    int m_next;
    bit m_pwm;
    bit m_fs;
    bit m_clamp;

    pwm_servo_generator #(
        .PERIOD_COUNT(P),
        .MIN_PULSE   (MINP),
        .MAX_PULSE   (MAXP),
        .DUTY_RESET  (RSTW),
        .CW          (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .duty_in    (duty_in),
        .duty_valid (duty_valid),
        .duty_ready (duty_ready),
        .pwm_out    (pwm_out),
        .frame_start(frame_start),
        .busy       (busy),
        .clamped    (clamped)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_on = 0; m_stopping = 0; m_pos = 0;
        m_width = RSTW; m_next = -1;
        m_pwm = 0; m_fs = 0; m_clamp = 0;
    endtask

    task automatic model_edge(input logic e, input logic v, input logic [CW-1:0] d);
        bit acc;
        int req;
        acc = v && (m_next < 0);
        req = int'(d);
        if (!m_on) begin
            if (m_next >= 0) begin m_width = m_next; m_next = -1; end
            m_pos = 0; m_stopping = 0;
            m_on = e; m_pwm = e; m_fs = e;
        end else begin
            m_pos = (m_pos + 1) % P;
            if (m_pos == 0 && m_next >= 0) begin m_width = m_next; m_next = -1; end
            if (m_pos == 0 && m_stopping && !e) begin
                m_on = 0; m_pwm = 0; m_fs = 0;
            end else begin
                m_pwm = (m_pos < m_width);
                m_fs  = (m_pos == 0);
            end
            m_stopping = !e;
        end
        m_clamp = acc && (req < MINP || req > MAXP);
        if (acc) m_next = (req < MINP) ? MINP : (req > MAXP) ? MAXP : req;
    endtask

    task automatic check_all();
        chk("pwm_out", pwm_out, m_pwm);
        chk("frame_start", frame_start, m_fs);
        chk("busy", busy, m_on);
        chk("duty_ready", duty_ready, m_next < 0);
        chk("clamped", clamped, m_clamp);
    endtask

    task automatic step(input logic e, input logic v, input logic [CW-1:0] d);
        en = e; duty_valid = v; duty_in = d;
        @(posedge clk);
        model_edge(e, v, d);
        #1;
        check_all();
    endtask

    // Runs one frame from its first cycle, counting high cycles; en low in [off_at, on_at).
    task automatic frame(input int off_at, input int on_at, input bit v,
                         input logic [CW-1:0] d, output int hi);
        hi = 0;
        for (int i = 0; i < P; i++) begin
            if (pwm_out) hi++;
            step(!(i >= off_at && i < on_at), v && (i == 3), d);
        end
    endtask

    initial begin
        int hi;
        bit en_r;
        model_reset();
        #12;
        chk("rst_pwm", pwm_out, 1'b0);
        chk("rst_fs", frame_start, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", duty_ready, 1'b1);
        chk("rst_clamped", clamped, 1'b0);
        #8 rst = 1'b0;

        // Start: pwm rises one cycle after en is sampled.
        step(1, 0, '0);
        chk("start_fs", frame_start, 1'b1);
        frame(99, 99, 0, '0, hi); chk_int("w_reset", hi, 10);
        chk("fs_aligned", frame_start, 1'b1);
        frame(99, 99, 1, 5'd6, hi); chk_int("w_cur_kept", hi, 10);
        frame(99, 99, 0, '0, hi); chk_int("w_6", hi, 6);
        frame(99, 99, 1, 5'd2, hi); chk_int("w_6b", hi, 6);
        frame(99, 99, 1, 5'd25, hi); chk_int("w_min", hi, 4);
        frame(99, 99, 1, 5'd16, hi); chk_int("w_max", hi, 16);
        frame(99, 99, 1, 5'd10, hi); chk_int("w_16", hi, 16);
        frame(99, 99, 0, '0, hi); chk_int("w_10", hi, 10);

        // Stop mid-frame: frame completes, then idle.
        frame(3, 99, 0, '0, hi); chk_int("w_stop", hi, 10);
        chk("stop_busy", busy, 1'b0);
        chk("stop_pwm", pwm_out, 1'b0);
        step(0, 0, '0);
        step(0, 0, '0);
        step(1, 0, '0);
        frame(3, 15, 0, '0, hi); chk_int("w_reen", hi, 10);
        chk("reen_fs", frame_start, 1'b1);
        chk("reen_busy", busy, 1'b1);
        frame(99, 99, 0, '0, hi); chk_int("w_reen2", hi, 10);

        // Async reset during a pulse discards a pending update.
        step(1, 1, 5'd6);
        step(1, 0, '0);
        chk("pre_rst_pwm", pwm_out, 1'b1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("arst_pwm", pwm_out, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_ready", duty_ready, 1'b1);
        #1 rst = 1'b0;
        step(1, 0, '0);
        frame(99, 99, 0, '0, hi); chk_int("w_after_rst", hi, 10);

        // Randomized traffic against the model.
        en_r = 1'b1;
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 39) == 0) en_r = !en_r;
            step(en_r, $urandom_range(0, 5) == 0, CW'($urandom_range(0, 31)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_servo_generator.md
Name: pwm_servo_generator

Overview:
- Transmit-side counterpart of the PWM pulse-width analyzer: generates a servo-style PWM frame whose high time is loaded through a valid/ready interface.
- Default timing, with a 1 us clock: 20 ms frame, 1000–2000 us pulse. This matches the analyzer's counter range and its 1100/1900 thresholds.
- Drives a pin that loops back into the analyzer's input for self-test.
- Pulse width is double-buffered and changes only at frame boundaries, so no frame is ever truncated or glitched.

Parameters:
- PERIOD_COUNT, 20000: clock cycles per frame.
- MIN_PULSE, 1000: minimum high time in cycles; lower requests are clamped up.
- MAX_PULSE, 2000: maximum high time in cycles; higher requests are clamped down. Must be < PERIOD_COUNT.
- DUTY_RESET, 1500: pulse width loaded at reset (neutral position).
- CW, 15: counter/duty width; must satisfy 2^CW > PERIOD_COUNT.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  run request, level-sensitive
- duty_in  in  CW  requested pulse width in cycles
- duty_valid  in  1  duty_in is valid
- duty_ready  out  1  shadow register can accept a new value
- pwm_out  out  1  registered PWM output
- frame_start  out  1  one-cycle pulse on the first cycle of every frame
- busy  out  1  state != IDLE
- clamped  out  1  one-cycle pulse: the accepted value was saturated

Behaviour:
- Reset (async, rst=1), effective immediately, including mid-frame:
  - state=IDLE, cnt=0, active=shadow=DUTY_RESET, pending=0.
  - pwm_out=0, frame_start=0, clamped=0, busy=0, duty_ready=1.
- Handshake:
  - duty_ready = !pending.
  - Accept on a rising edge where duty_valid && duty_ready: shadow <= clamp(duty_in, MIN_PULSE, MAX_PULSE); pending <= 1.
  - clamped <= 1 on the following cycle if saturation occurred, else 0.
  - Once accepted, the request is not re-sampled.
- Shadow-to-active transfer:
  - In IDLE: on the edge after acceptance (pending cleared).
  - In RUN/STOP: only at a frame wrap (pending cleared on the same edge).
  - A value accepted on the wrap edge itself takes effect in the following frame; at most one update per frame.
- FSM:
  - IDLE: pwm_out=0, cnt held at 0. If en=1 on an edge, go to RUN with cnt<=0, active<=shadow if pending, pwm_out<=1, frame_start<=1. So pwm_out rises exactly one cycle after en is sampled high.
  - RUN, every edge: cnt <= (cnt==PERIOD_COUNT-1) ? 0 : cnt+1; pwm_out <= (next_cnt < next_active).
    - frame_start <= (next_cnt==0).
    - High time per frame is exactly active cycles; low time is PERIOD_COUNT-active.
    - If en=0, go to STOP; the frame keeps running unchanged.
  - STOP: identical counting and output to RUN.
    - At wrap: IDLE, with pwm_out<=0 and frame_start stays 0.
    - If en returns to 1 before wrap, go back to RUN with no gap and no phase change.
- Boundaries:
  - en toggling within a frame never shortens a pulse.
  - Because MIN_PULSE ≥ 1, every running frame contains a pulse; at MAX_PULSE < PERIOD_COUNT it still falls before the frame ends.
  - duty_in equal to MIN_PULSE or MAX_PULSE is not flagged clamped.
- All outputs are registered except duty_ready and busy, which are decoded directly from state/pending registers.

Decomposition:
- Shared package/header pwm_pkg:
  - State encoding: IDLE=2'd0, RUN=2'd1, STOP=2'd2.
  - Default timing constants (PERIOD/MIN/MAX/RESET).
  - clamp function.
  - Reused by the analyzer bench.
- One sub-module, pwm_frame_counter:
  - Modulo-PERIOD_COUNT counter with clear and enable.
  - Outputs next_cnt and wrap.
- FSM, shadow/handshake and output compare live in the top.

Test Plan (PERIOD_COUNT=20, MIN_PULSE=4, MAX_PULSE=16, DUTY_RESET=10, CW=5):
- Reset then en=1 → pwm_out high 10 cycles, low 10, repeating; frame_start every 20 cycles, aligned with pwm_out rising; busy=1.
- Mid-frame, send duty_in=6 with valid → duty_ready drops for the rest of the frame; the current frame stays 10 high; the next frame is 6 high; ready returns at the wrap.
- duty_in=2, then (next frame) duty_in=25 → clamped pulses each time; the following frames are 4 and 16 high respectively; duty_in=16 → no clamped pulse.
- en=0 at cycle 3 of a frame → frame completes (10 high, 10 low); then IDLE with pwm_out=0 and busy=0. A second run re-asserts en at cycle 15 of a frame → no gap, continuous frames.
- rst=1 asynchronously during a pulse → pwm_out=0 before the next clock edge. After release with en=1 → 10-cycle pulse; the earlier update is discarded.
- Loopback into the analyzer (defaults, 1 us clock), duty 1000/1500/2000 → analyzer reports LOW/mid/HIGH respectively.
